// File: rtl/ram_pkg.sv
// Shared types and constants for the single-write, multi-read RAM.
// Holds default-sized word/address typedefs, configuration limits and
// a helper that locates a port's slice inside a flattened port vector.
package ram_pkg;

  localparam int RAM_WIDTH       = 32;
  localparam int RAM_ADDR_W      = 5;
  localparam int MAX_NUM_READ    = 8;
  localparam int MAX_WRITE_DELAY = 4;

  typedef logic [RAM_WIDTH-1:0]  ram_data_t;
  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;

  // Low bit index of element idx in a flattened vector of w-bit elements.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/ram_delay_line.sv
// Fixed-length shift pipeline carrying a payload and a parallel valid chain.
// Reset clears only the valid bits; payload registers are left free-running.
// With RAM_WR_FWD_EN defined, every stage is exported so the read ports can
// forward in-flight writes. STAGES=0 degenerates to a wire.
module ram_delay_line #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic [WIDTH-1:0]                     in_data,
  output logic                                 out_valid,
  output logic [WIDTH-1:0]                     out_data,
  output logic                                 any_valid
`ifdef RAM_WR_FWD_EN
  ,
  output logic [(STAGES > 0 ? STAGES : 1)-1:0]         stage_valid,
  output logic [(STAGES > 0 ? STAGES : 1)*WIDTH-1:0]   stage_data
`endif
);

  if (STAGES == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign any_valid = 1'b0;
`ifdef RAM_WR_FWD_EN
    assign stage_valid = '0;
    assign stage_data  = '0;
`endif
  end else begin : g_pipe
    logic [STAGES-1:0] valid_reg;
    logic [WIDTH-1:0]  data_reg [STAGES];

    // Valid chain: stage 0 is the youngest entry; cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_reg <= '0;
      end else begin
        valid_reg[0] <= in_valid;
        for (int s = 1; s < STAGES; s++) begin
          valid_reg[s] <= valid_reg[s-1];
        end
      end
    end

    // Payload chain shifts every cycle; only the valid bit gives it meaning.
    always_ff @(posedge clk) begin
      data_reg[0] <= in_data;
      for (int s = 1; s < STAGES; s++) begin
        data_reg[s] <= data_reg[s-1];
      end
    end

    assign out_valid = valid_reg[STAGES-1];
    assign out_data  = data_reg[STAGES-1];
    assign any_valid = |valid_reg;

`ifdef RAM_WR_FWD_EN
    assign stage_valid = valid_reg;
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      assign stage_data[gi*WIDTH +: WIDTH] = data_reg[gi];
    end
`endif
  end

endmodule

// File: rtl/ram_1w_nr_param.sv
// Single-write, N-read synchronous RAM with a delayed write commit,
// per-port registered reads and side-band debug read/write access.
// Optional feature macro: RAM_WR_FWD_EN -- forwards in-flight writes
// (pipeline stages and same-edge debug write) to the read ports.
module ram_1w_nr_param
  import ram_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int NUM_READ    = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_READ*ADDR_W-1:0]   raddr,
  input  logic [NUM_READ-1:0]          ren,
  output logic [NUM_READ*WIDTH-1:0]    rdata,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         wen,
  output logic                         wr_pending,
  input  logic [ADDR_W-1:0]            debug_addr,
  output logic [WIDTH-1:0]             debug_data,
  input  logic [ADDR_W-1:0]            debug_write_addr,
  input  logic [WIDTH-1:0]             debug_write_data,
  input  logic                         debug_write_en
);

  localparam int              PKT_W   = ADDR_W + WIDTH;
  localparam int              SLOTS   = (WRITE_DELAY > 0) ? WRITE_DELAY : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  if (NUM_READ < 1 || NUM_READ > MAX_NUM_READ) begin : g_bad_num_read
    $error("NUM_READ out of range");
  end
  if (WRITE_DELAY < 0 || WRITE_DELAY > MAX_WRITE_DELAY) begin : g_bad_delay
    $error("WRITE_DELAY out of range");
  end

  // Addresses at or beyond DEPTH are silently ignored on every path.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              commit_valid;
  logic [PKT_W-1:0]  commit_pkt;
  logic [ADDR_W-1:0] commit_addr;
  logic [WIDTH-1:0]  commit_data;
`ifdef RAM_WR_FWD_EN
  logic [SLOTS-1:0]       stage_valid;
  logic [SLOTS*PKT_W-1:0] stage_data;
`endif

  ram_delay_line #(
    .WIDTH  (PKT_W),
    .STAGES (WRITE_DELAY)
  ) u_wr_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (wen),
    .in_data   ({waddr, wdata}),
    .out_valid (commit_valid),
    .out_data  (commit_pkt),
    .any_valid (wr_pending)
`ifdef RAM_WR_FWD_EN
    ,
    .stage_valid (stage_valid),
    .stage_data  (stage_data)
`endif
  );

  assign commit_addr = commit_pkt[WIDTH +: ADDR_W];
  assign commit_data = commit_pkt[WIDTH-1:0];

  // Array update: pipeline commit first, debug write last so it wins a collision.
  always_ff @(posedge clk) begin
    if (commit_valid && in_range(commit_addr)) begin
      mem[commit_addr] <= commit_data;
    end
    if (debug_write_en && in_range(debug_write_addr)) begin
      mem[debug_write_addr] <= debug_write_data;
    end
  end

  assign debug_data = in_range(debug_addr) ? mem[debug_addr] : '0;

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    localparam int AL = slice_lo(gi, ADDR_W);
    localparam int DL = slice_lo(gi, WIDTH);

    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  rd_next;
    logic [WIDTH-1:0]  rd_reg;

    assign addr = raddr[AL +: ADDR_W];

`ifdef RAM_WR_FWD_EN
    // Read source select: array, then older-to-younger stages, then debug write.
    always_comb begin
      rd_next = mem[addr];
      if (WRITE_DELAY == 0) begin
        if (wen && in_range(waddr) && waddr == addr) begin
          rd_next = wdata;
        end
      end else begin
        for (int s = SLOTS - 1; s >= 0; s--) begin
          if (stage_valid[s] &&
              in_range(stage_data[s*PKT_W + WIDTH +: ADDR_W]) &&
              stage_data[s*PKT_W + WIDTH +: ADDR_W] == addr) begin
            rd_next = stage_data[s*PKT_W +: WIDTH];
          end
        end
      end
      if (debug_write_en && debug_write_addr == addr) begin
        rd_next = debug_write_data;
      end
      if (!in_range(addr)) begin
        rd_next = '0;
      end
    end
`else
    // Read source: array contents only (read-before-write on collisions).
    always_comb begin
      rd_next = '0;
      if (in_range(addr)) begin
        rd_next = mem[addr];
      end
    end
`endif

    // Registered read port; holds its value while ren is low.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_reg <= '0;
      end else if (ren[gi]) begin
        rd_reg <= rd_next;
      end
    end

    assign rdata[DL +: WIDTH] = rd_reg;
  end

endmodule

// File: tb/tb_ram_1w_nr_param.sv
// Self-checking bench for ram_1w_nr_param (WRITE_DELAY=2, three read ports,
// DEPTH smaller than the address space). Honours RAM_WR_FWD_EN if defined.
module tb_ram_1w_nr_param;

  localparam int W  = 32;
  localparam int D  = 24;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int WD = 2;

  logic              clk;
  logic              rst;
  logic [NR*AW-1:0]  raddr;
  logic [NR-1:0]     ren;
  logic [NR*W-1:0]   rdata;
  logic [AW-1:0]     waddr;
  logic [W-1:0]      wdata;
  logic              wen;
  logic              wr_pending;
  logic [AW-1:0]     debug_addr;
  logic [W-1:0]      debug_data;
  logic [AW-1:0]     debug_write_addr;
  logic [W-1:0]      debug_write_data;
  logic              debug_write_en;

  ram_1w_nr_param #(
    .WIDTH(W), .DEPTH(D), .ADDR_W(AW), .NUM_READ(NR), .WRITE_DELAY(WD)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .raddr            (raddr),
    .ren              (ren),
    .rdata            (rdata),
    .waddr            (waddr),
    .wdata            (wdata),
    .wen              (wen),
    .wr_pending       (wr_pending),
    .debug_addr       (debug_addr),
    .debug_data       (debug_data),
    .debug_write_addr (debug_write_addr),
    .debug_write_data (debug_write_data),
    .debug_write_en   (debug_write_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int         addr;
    logic [W-1:0] data;
    int         due;
  } wr_t;

  logic [W-1:0] m_mem [D];
  logic [W-1:0] m_rd  [NR];
  wr_t          pend[$];
  int           cyc = 0;
  int           a_m;
  logic [W-1:0] v_m;
  wr_t          nw_m;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend.delete();
      for (int i = 0; i < NR; i++) m_rd[i] = '0;
    end else begin
      cyc++;
      // reads see the memory before this edge's commits
      for (int i = 0; i < NR; i++) begin
        if (ren[i]) begin
          a_m = int'(raddr[i*AW +: AW]);
          if (a_m >= D) begin
            v_m = '0;
          end else begin
            v_m = m_mem[a_m];
`ifdef RAM_WR_FWD_EN
            if (WD == 0 && wen && int'(waddr) == a_m) v_m = wdata;
            foreach (pend[k]) if (pend[k].addr == a_m) v_m = pend[k].data;
            if (debug_write_en && int'(debug_write_addr) == a_m) v_m = debug_write_data;
`endif
          end
          m_rd[i] = v_m;
        end
      end
      while (pend.size() > 0 && pend[0].due == cyc) begin
        if (pend[0].addr < D) m_mem[pend[0].addr] = pend[0].data;
        void'(pend.pop_front());
      end
      if (wen) begin
        nw_m.addr = int'(waddr);
        nw_m.data = wdata;
        nw_m.due  = cyc + WD;
        if (WD == 0) begin
          if (nw_m.addr < D) m_mem[nw_m.addr] = nw_m.data;
        end else begin
          pend.push_back(nw_m);
        end
      end
      if (debug_write_en && int'(debug_write_addr) < D) m_mem[debug_write_addr] = debug_write_data;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en && rst) begin
      for (int i = 0; i < NR; i++) begin
        check($sformatf("cyc%0d rdata%0d", cyc, i), rdata[i*W +: W], m_rd[i]);
      end
      check($sformatf("cyc%0d wr_pending", cyc), {31'd0, wr_pending}, {31'd0, pend.size() != 0});
      check($sformatf("cyc%0d debug_data", cyc), debug_data,
            (int'(debug_addr) < D) ? m_mem[debug_addr] : '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] pre [12] = '{6, 1, 2, 3, 7, 5, 5, 2, 9, 9, 3, 7};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; raddr = '0; ren = '0; waddr = '0; wdata = '0; wen = 1'b0;
    debug_addr = '0; debug_write_addr = '0; debug_write_data = '0; debug_write_en = 1'b0;
    tick(); tick();
    for (int i = 0; i < NR; i++) check($sformatf("reset rdata%0d", i), rdata[i*W +: W], '0);
    check("reset wr_pending", {31'd0, wr_pending}, 32'd0);
    rst = 1'b1;

    // preload every word via the debug port
    for (int a = 0; a < D; a++) begin
      debug_write_en   = 1'b1;
      debug_write_addr = AW'(a);
      debug_write_data = (a < 12) ? pre[a] : W'(200 + a);
      tick();
    end
    debug_write_en = 1'b0;
    for (int a = 0; a < 12; a++) begin
      debug_addr = AW'(a);
      #1;
      check($sformatf("preload addr%0d", a), debug_data, pre[a]);
    end
    chk_en = 1'b1;

    // delayed write commit
    debug_addr = 5'd12;
    waddr = 5'd12; wdata = 32'd71; wen = 1'b1;
    tick();
    wen = 1'b0;
    check("wdelay pending t+1", {31'd0, wr_pending}, 32'd1);
    check("wdelay old t+1", debug_data, 32'd212);
    tick();
    check("wdelay pending t+2", {31'd0, wr_pending}, 32'd1);
    check("wdelay old t+2", debug_data, 32'd212);
    tick();
    check("wdelay pending done", {31'd0, wr_pending}, 32'd0);
    check("wdelay new", debug_data, 32'd71);

    // per-port enables
    raddr = {5'd0, 5'd1, 5'd0}; ren = 3'b010;
    tick();
    ren = 3'b000;
    check("port1 read addr1", rdata[1*W +: W], 32'd1);
    raddr = {5'd4, 5'd0, 5'd8}; ren = 3'b101;
    tick();
    ren = 3'b000;
    check("ren101 rdata0", rdata[0*W +: W], 32'd9);
    check("ren101 rdata2", rdata[2*W +: W], 32'd7);
    check("ren101 rdata1 held", rdata[1*W +: W], 32'd1);

    // debug write beats a same-edge pipeline commit
    waddr = 5'd13; wdata = 32'd83; wen = 1'b1;
    tick();
    wen = 1'b0;
    tick();
    debug_write_addr = 5'd13; debug_write_data = 32'd5; debug_write_en = 1'b1;
    tick();
    debug_write_en = 1'b0;
    debug_addr = 5'd13;
    #1;
    check("collision mem13", debug_data, 32'd5);

    // read-after-write while the write is in flight
    waddr = 5'd14; wdata = 32'd114; wen = 1'b1;
    tick();
    wen = 1'b0;
    raddr = {5'd0, 5'd0, 5'd14}; ren = 3'b001;
    tick();
    ren = 3'b000;
`ifdef RAM_WR_FWD_EN
    check("raw addr14 forwarded", rdata[0*W +: W], 32'd114);
`else
    check("raw addr14 stale", rdata[0*W +: W], 32'd214);
`endif
    tick(); tick();

    // out-of-range read returns zero; out-of-range write still occupies the pipe
    raddr = {5'd2, 5'd30, 5'd23}; ren = 3'b111;
    waddr = 5'd25; wdata = 32'd77; wen = 1'b1;
    tick();
    ren = 3'b000; wen = 1'b0;
    check("oob read rdata1", rdata[1*W +: W], 32'd0);
    check("edge read addr23", rdata[0*W +: W], 32'd223);
    check("oob write pending", {31'd0, wr_pending}, 32'd1);
    tick(); tick();

    // back-to-back writes with reads hitting them in flight
    for (int k = 0; k < 3; k++) begin
      waddr = AW'(15 + k); wdata = W'(1500 + k); wen = 1'b1;
      raddr = {AW'(15 + k), AW'(16), AW'(15)}; ren = 3'b111;
      tick();
    end
    wen = 1'b0; ren = 3'b000;
    tick(); tick();
    raddr = {5'd17, 5'd16, 5'd15}; ren = 3'b111;
    tick();
    ren = 3'b000;
    check("b2b rdata0", rdata[0*W +: W], 32'd1500);
    check("b2b rdata1", rdata[1*W +: W], 32'd1501);
    check("b2b rdata2", rdata[2*W +: W], 32'd1502);

    // reset while a write is pending
    raddr = {5'd4, 5'd8, 5'd0}; ren = 3'b111;
    waddr = 5'd18; wdata = 32'd999; wen = 1'b1;
    tick();
    ren = 3'b000; wen = 1'b0;
    check("pre-reset pending", {31'd0, wr_pending}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) check($sformatf("async reset rdata%0d", i), rdata[i*W +: W], '0);
    check("async reset pending", {31'd0, wr_pending}, 32'd0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick(); tick();
    debug_addr = 5'd18;
    #1;
    check("reset discards write", debug_data, 32'd218);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
